// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: divides clk down to a pixel strobe, walks the
// x/y raster and produces sync, blanking and line/frame start strobes.
// Sync and blanking are registered from the next-state coordinates, so they
// line up with x/y in the same clock.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 4,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int XBITS     = 10,
  parameter int YBITS     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             pixel_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             activevideo,
  output logic [XBITS-1:0] x,
  output logic [YBITS-1:0] y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = H_VISIBLE + H_FRONT + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = V_VISIBLE + V_FRONT + V_SYNC;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [XBITS-1:0] X_LAST   = XBITS'(H_TOTAL - 1);
  localparam logic [YBITS-1:0] Y_LAST   = YBITS'(V_TOTAL - 1);

  // Reject geometries the counters or divider cannot represent.
  if (CLK_DIV < 1) begin : g_div_err
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if ((H_TOTAL - 1) >= (1 << XBITS)) begin : g_xbits_err
    $error("vga_timing_gen: XBITS too narrow for H_TOTAL-1");
  end
  if ((V_TOTAL - 1) >= (1 << YBITS)) begin : g_ybits_err
    $error("vga_timing_gen: YBITS too narrow for V_TOTAL-1");
  end

  logic [DIV_W-1:0] div_reg, div_next;
  logic             tick_reg;
  logic [XBITS-1:0] x_reg, x_next;
  logic [YBITS-1:0] y_reg, y_next;
  logic             x_wrap, frame_wrap;
  logic             ls_reg, fs_reg;
  logic             hs_reg, vs_reg, av_reg;
  logic             hs_on, vs_on, av_on;

  // Next-state divider, raster position and decode of that next position.
  // tick_reg is held (not cleared) across an enable=0 hold so the pending
  // pixel advance is applied on the first enabled edge after resume.
  always_comb begin
    div_next   = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
    x_wrap     = (x_reg == X_LAST);
    frame_wrap = x_wrap && (y_reg == Y_LAST);
    x_next     = x_reg;
    y_next     = y_reg;
    if (tick_reg) begin
      x_next = x_wrap ? '0 : x_reg + 1'b1;
      if (x_wrap) begin
        y_next = (y_reg == Y_LAST) ? '0 : y_reg + 1'b1;
      end
    end
    hs_on = (32'(x_next) >= HS_START) && (32'(x_next) < HS_END);
    vs_on = (32'(y_next) >= VS_START) && (32'(y_next) < VS_END);
    av_on = (32'(x_next) < H_VISIBLE) && (32'(y_next) < V_VISIBLE);
  end

  // Clock divider and registered pixel strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg  <= '0;
      tick_reg <= 1'b0;
    end else if (enable) begin
      div_reg  <= div_next;
      tick_reg <= (div_reg == DIV_LAST);
    end
  end

  // Raster counters and start-of-line / start-of-frame strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_reg  <= '0;
      y_reg  <= '0;
      ls_reg <= 1'b0;
      fs_reg <= 1'b0;
    end else if (enable) begin
      x_reg  <= x_next;
      y_reg  <= y_next;
      ls_reg <= tick_reg && x_wrap;
      fs_reg <= tick_reg && frame_wrap;
    end
  end

  // Sync and blanking registered from next-state x/y (zero skew to x/y).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_reg <= ~HSYNC_POL;
      vs_reg <= ~VSYNC_POL;
      av_reg <= 1'b1;
    end else if (enable) begin
      hs_reg <= hs_on ? HSYNC_POL : ~HSYNC_POL;
      vs_reg <= vs_on ? VSYNC_POL : ~VSYNC_POL;
      av_reg <= av_on;
    end
  end

  // Strobes are masked while frozen so a held state never repeats a pulse.
  assign pixel_tick  = tick_reg & enable;
  assign line_start  = ls_reg & enable;
  assign frame_start = fs_reg & enable;
  assign hsync       = hs_reg;
  assign vsync       = vs_reg;
  assign activevideo = av_reg;
  assign x           = x_reg;
  assign y           = y_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed testbench for vga_timing_gen: three instances (default 640x480
// timing, CLK_DIV=1 with positive syncs, and a tiny raster for whole frames).
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance A: all defaults
  logic       rst_a = 1'b1, en_a = 1'b1;
  logic       tick_a, hs_a, vs_a, av_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;

  vga_timing_gen dut_a (
    .clk(clk), .reset(rst_a), .enable(en_a), .pixel_tick(tick_a),
    .hsync(hs_a), .vsync(vs_a), .activevideo(av_a), .x(x_a), .y(y_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  // Instance B: CLK_DIV=1, active-high syncs, short frame (8 lines)
  logic       rst_b = 1'b1, en_b = 1'b1;
  logic       tick_b, hs_b, vs_b, av_b, ls_b, fs_b;
  logic [9:0] x_b;
  logic [3:0] y_b;

  vga_timing_gen #(
    .CLK_DIV(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .YBITS(4)
  ) dut_b (
    .clk(clk), .reset(rst_b), .enable(en_b), .pixel_tick(tick_b),
    .hsync(hs_b), .vsync(vs_b), .activevideo(av_b), .x(x_b), .y(y_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  // Instance C: 15x12 raster, CLK_DIV=2, active-low syncs
  logic       rst_c = 1'b1, en_c = 1'b1;
  logic       tick_c, hs_c, vs_c, av_c, ls_c, fs_c;
  logic [3:0] x_c, y_c;

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
    .CLK_DIV(2), .XBITS(4), .YBITS(4)
  ) dut_c (
    .clk(clk), .reset(rst_c), .enable(en_c), .pixel_tick(tick_c),
    .hsync(hs_c), .vsync(vs_c), .activevideo(av_c), .x(x_c), .y(y_c),
    .line_start(ls_c), .frame_start(fs_c)
  );

  task automatic test_reset();
    rst_a = 1'b1;
    en_a  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (x_a !== 10'd0 || y_a !== 10'd0) begin
      failures++;
      $display("FAIL reset_xy: got x=%0d y=%0d, expected x=0 y=0", x_a, y_a);
    end
    checks++;
    if ({av_a, hs_a, vs_a} !== 3'b111) begin
      failures++;
      $display("FAIL reset_decode: got av/hs/vs=%b, expected 111", {av_a, hs_a, vs_a});
    end
    checks++;
    if ({tick_a, ls_a, fs_a} !== 3'b000) begin
      failures++;
      $display("FAIL reset_strobes: got tick/ls/fs=%b, expected 000", {tick_a, ls_a, fs_a});
    end
    $display("test_reset done");
  endtask

  // Two full lines from reset release with default timing.
  task automatic test_line();
    int first_tick = 0, last_tick = 0, bad_gap = 0, ntick = 0;
    int hs_min = 9999, hs_max = -1, hs_cnt = 0, av_min = 9999, av_cnt = 0;
    int hs_incons = 0, av_incons = 0, ls1 = 0, ls2 = 0, nls = 0, nfs = 0;
    int ticks_l1 = 0, ticks_l2 = 0;
    logic exp_hs, exp_av;
    rst_a = 1'b0;
    for (int c = 1; c <= 6402; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (tick_a) begin
        if (first_tick == 0) first_tick = c;
        else if (c - last_tick != 4) bad_gap++;
        last_tick = c;
        ntick++;
        if (c < 3201) ticks_l1++;
        else if (c > 3201 && c < 6401) ticks_l2++;
      end
      exp_hs = !((x_a >= 656) && (x_a < 752));
      exp_av = (x_a < 640) && (y_a < 480);
      if (hs_a !== exp_hs) hs_incons++;
      if (av_a !== exp_av) av_incons++;
      if (y_a == 0 && hs_a == 1'b0) begin
        hs_cnt++;
        if (int'(x_a) < hs_min) hs_min = int'(x_a);
        if (int'(x_a) > hs_max) hs_max = int'(x_a);
      end
      if (y_a == 0 && av_a == 1'b0) begin
        av_cnt++;
        if (int'(x_a) < av_min) av_min = int'(x_a);
      end
      if (ls_a) begin
        nls++;
        if (ls1 == 0) ls1 = c;
        else ls2 = c;
      end
      if (fs_a) nfs++;
    end
    checks++;
    if (first_tick != 4) begin
      failures++;
      $display("FAIL line_first_tick: got clk %0d, expected 4", first_tick);
    end
    checks++;
    if (bad_gap != 0 || ntick != 1600) begin
      failures++;
      $display("FAIL line_tick_period: got bad_gaps=%0d ticks=%0d, expected 0 and 1600", bad_gap, ntick);
    end
    checks++;
    if (hs_min != 656 || hs_max != 751 || hs_cnt != 384) begin
      failures++;
      $display("FAIL line_hsync_window: got x=%0d..%0d cnt=%0d, expected 656..751 cnt=384", hs_min, hs_max, hs_cnt);
    end
    checks++;
    if (av_min != 640 || av_cnt != 640) begin
      failures++;
      $display("FAIL line_blank_window: got first x=%0d cnt=%0d, expected 640 and 640", av_min, av_cnt);
    end
    checks++;
    if (hs_incons != 0 || av_incons != 0) begin
      failures++;
      $display("FAIL line_decode_skew: got hs_bad=%0d av_bad=%0d, expected 0 0", hs_incons, av_incons);
    end
    checks++;
    if (ls1 != 3201 || ls2 != 6401 || nls != 2) begin
      failures++;
      $display("FAIL line_start_timing: got %0d,%0d n=%0d, expected 3201,6401 n=2", ls1, ls2, nls);
    end
    checks++;
    if (ticks_l1 != 800 || ticks_l2 != 800) begin
      failures++;
      $display("FAIL line_ticks_per_line: got %0d,%0d, expected 800,800", ticks_l1, ticks_l2);
    end
    checks++;
    if (nfs != 0 || x_a !== 10'd0 || y_a !== 10'd2) begin
      failures++;
      $display("FAIL line_end_state: got fs=%0d x=%0d y=%0d, expected 0, 0, 2", nfs, x_a, y_a);
    end
    $display("test_line done: ticks=%0d line_starts=%0d", ntick, nls);
  endtask

  // Freeze at x=100 mid-divide; the line must still total 800 ticks.
  task automatic test_enable();
    int ticks_line = 0, hold_bad = 0, resume_k = 0;
    bit found = 0, ls_seen = 0;
    logic [9:0] x0, y0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (tick_a) ticks_line++;
      if (x_a == 10'd100) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL enable_reach_x100: got x=%0d, expected 100 within 1000 clks", x_a);
    end
    @(posedge clk);
    @(negedge clk);
    if (tick_a) ticks_line++;
    x0 = x_a;
    y0 = y_a;
    en_a = 1'b0;
    for (int c = 0; c < 37; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (x_a !== x0 || y_a !== y0 || tick_a || ls_a || fs_a) hold_bad++;
    end
    checks++;
    if (hold_bad != 0) begin
      failures++;
      $display("FAIL enable_hold: got %0d bad hold cycles, expected 0", hold_bad);
    end
    en_a = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (tick_a) begin
        ticks_line++;
        resume_k = k;
        break;
      end
    end
    checks++;
    if (resume_k != 2) begin
      failures++;
      $display("FAIL enable_resume_div: got first tick %0d clks after resume, expected 2", resume_k);
    end
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ls_a) begin
        ls_seen = 1;
        break;
      end
      if (tick_a) ticks_line++;
    end
    checks++;
    if (!ls_seen || ticks_line != 800 || y_a !== 10'd3) begin
      failures++;
      $display("FAIL enable_line_total: got ls=%0d ticks=%0d y=%0d, expected 1, 800, 3", ls_seen, ticks_line, y_a);
    end
    $display("test_enable done: ticks_in_line=%0d", ticks_line);
  endtask

  // Asynchronous reset pulse mid-line, then restart timing.
  task automatic test_reset_mid();
    int first = 0, nstrobe = 0, xmove = 0;
    bit found = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (x_a == 10'd700) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found || hs_a !== 1'b0 || av_a !== 1'b0) begin
      failures++;
      $display("FAIL midreset_pre: got found=%0d hs=%b av=%b at x=700, expected 1 0 0", found, hs_a, av_a);
    end
    #2 rst_a = 1'b1;
    #1;
    checks++;
    if (x_a !== 10'd0 || y_a !== 10'd0 || {av_a, hs_a, vs_a} !== 3'b111 || {tick_a, ls_a, fs_a} !== 3'b000) begin
      failures++;
      $display("FAIL midreset_async: got x=%0d y=%0d av/hs/vs=%b strobes=%b, expected 0 0 111 000",
               x_a, y_a, {av_a, hs_a, vs_a}, {tick_a, ls_a, fs_a});
    end
    @(negedge clk);
    rst_a = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (ls_a || fs_a) nstrobe++;
      if (x_a !== 10'd0) xmove++;
      if (tick_a) begin
        first = k;
        break;
      end
    end
    checks++;
    if (first != 4 || nstrobe != 0 || xmove != 0) begin
      failures++;
      $display("FAIL midreset_restart: got first tick=%0d strobes=%0d xmoves=%0d, expected 4 0 0", first, nstrobe, xmove);
    end
    $display("test_reset_mid done: first_tick=%0d", first);
  endtask

  // CLK_DIV=1 with active-high syncs over one 8-line frame.
  task automatic test_pol_clkdiv1();
    int first = 0, ntick = 0, hs_min = 9999, hs_max = -1, hs_cnt = 0;
    int vs_min = 9999, vs_max = -1, vs_cnt = 0, incons = 0, nls = 0, nfs = 0, fs_at = 0;
    logic exp_hs, exp_vs;
    @(negedge clk);
    rst_b = 1'b0;
    for (int c = 1; c <= 6402; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (tick_b) begin
        ntick++;
        if (first == 0) first = c;
      end
      exp_hs = (x_b >= 656) && (x_b < 752);
      exp_vs = (y_b >= 5) && (y_b < 7);
      if (hs_b !== exp_hs || vs_b !== exp_vs) incons++;
      if (y_b == 0 && hs_b == 1'b1) begin
        hs_cnt++;
        if (int'(x_b) < hs_min) hs_min = int'(x_b);
        if (int'(x_b) > hs_max) hs_max = int'(x_b);
      end
      if (vs_b == 1'b1) begin
        vs_cnt++;
        if (int'(y_b) < vs_min) vs_min = int'(y_b);
        if (int'(y_b) > vs_max) vs_max = int'(y_b);
      end
      if (ls_b) nls++;
      if (fs_b) begin
        nfs++;
        fs_at = c;
      end
    end
    checks++;
    if (first != 1 || ntick != 6402) begin
      failures++;
      $display("FAIL div1_ticks: got first=%0d count=%0d, expected 1 and 6402", first, ntick);
    end
    checks++;
    if (hs_min != 656 || hs_max != 751 || hs_cnt != 96) begin
      failures++;
      $display("FAIL div1_hsync_high: got x=%0d..%0d cnt=%0d, expected 656..751 cnt=96", hs_min, hs_max, hs_cnt);
    end
    checks++;
    if (vs_min != 5 || vs_max != 6 || vs_cnt != 1600) begin
      failures++;
      $display("FAIL div1_vsync_high: got y=%0d..%0d cnt=%0d, expected 5..6 cnt=1600", vs_min, vs_max, vs_cnt);
    end
    checks++;
    if (incons != 0) begin
      failures++;
      $display("FAIL div1_decode: got %0d inconsistent cycles, expected 0", incons);
    end
    checks++;
    if (nls != 8 || nfs != 1 || fs_at != 6401) begin
      failures++;
      $display("FAIL div1_strobes: got ls=%0d fs=%0d at %0d, expected 8, 1 at 6401", nls, nfs, fs_at);
    end
    $display("test_pol_clkdiv1 done: ticks=%0d", ntick);
  endtask

  // Two-plus frames on the small raster (CLK_DIV=2, 360 clks/frame).
  task automatic test_frames();
    int first = 0, nls = 0, nfs = 0, fs1 = 0, fs2 = 0, fs_no_ls = 0;
    int vs_min = 9999, vs_max = -1, vs_cnt = 0, incons = 0;
    logic exp_vs, exp_av;
    @(negedge clk);
    rst_c = 1'b0;
    for (int c = 1; c <= 800; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (tick_c && first == 0) first = c;
      exp_vs = !((y_c >= 7) && (y_c < 9));
      exp_av = (x_c < 8) && (y_c < 6);
      if (vs_c !== exp_vs || av_c !== exp_av) incons++;
      if (vs_c == 1'b0) begin
        vs_cnt++;
        if (int'(y_c) < vs_min) vs_min = int'(y_c);
        if (int'(y_c) > vs_max) vs_max = int'(y_c);
      end
      if (ls_c) nls++;
      if (fs_c) begin
        nfs++;
        if (!ls_c) fs_no_ls++;
        if (fs1 == 0) fs1 = c;
        else fs2 = c;
      end
    end
    checks++;
    if (first != 2) begin
      failures++;
      $display("FAIL frame_first_tick: got clk %0d, expected 2", first);
    end
    checks++;
    if (vs_min != 7 || vs_max != 8 || vs_cnt != 120) begin
      failures++;
      $display("FAIL frame_vsync_window: got y=%0d..%0d cnt=%0d, expected 7..8 cnt=120", vs_min, vs_max, vs_cnt);
    end
    checks++;
    if (incons != 0) begin
      failures++;
      $display("FAIL frame_decode: got %0d inconsistent cycles, expected 0", incons);
    end
    checks++;
    if (nfs != 2 || fs1 != 361 || fs2 != 721) begin
      failures++;
      $display("FAIL frame_start_timing: got n=%0d at %0d,%0d, expected n=2 at 361,721", nfs, fs1, fs2);
    end
    checks++;
    if (fs_no_ls != 0 || nls != 26) begin
      failures++;
      $display("FAIL frame_line_starts: got fs_without_ls=%0d ls=%0d, expected 0 and 26", fs_no_ls, nls);
    end
    $display("test_frames done: frame_starts=%0d line_starts=%0d", nfs, nls);
  endtask

  initial begin
    test_reset();
    test_line();
    test_enable();
    test_reset_mid();
    test_pol_clkdiv1();
    test_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
